// File: rtl/alu_seq_ctrl.sv
// Three-state sequencer around an external combinational ALU: captures one
// instruction, presents decoded operands for one cycle, then writes back.
module alu_seq_ctrl #(
  parameter int DATA_W = 16,
  parameter int NREG   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [7:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [4:0]        alu_flags,
  output logic [4:0]        psr,
  output logic              done,
  output logic              err,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  logic [1:0]        state;
  logic [15:0]       instr_p0;
  logic              done_p1;
  logic [DATA_W-1:0] regs [NREG];

  logic [3:0]        op;
  logic [3:0]        rdest;
  logic [3:0]        ext;
  logic [3:0]        src;
  logic              legal;
  logic              in_exec;
  logic              accept;
  logic              wr_en;
  logic              psr_en;
  logic [7:0]        opc_d;
  logic [DATA_W-1:0] a_d;
  logic [DATA_W-1:0] b_d;

  function automatic logic signed [DATA_W-1:0] sext8(input logic signed [7:0] v);
    return {{(DATA_W-8){v[7]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] zext8(input logic [7:0] v);
    return {{(DATA_W-8){1'b0}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] zext4(input logic [3:0] v);
    return {{(DATA_W-4){1'b0}}, v};
  endfunction

  assign op          = instr_p0[15:12];
  assign rdest       = instr_p0[11:8];
  assign ext         = instr_p0[7:4];
  assign src         = instr_p0[3:0];
  assign in_exec     = (state == EXEC);
  assign instr_ready = (state == IDLE);
  assign accept      = instr_valid & instr_ready;
  assign dbg_data    = regs[dbg_addr];

  always_comb begin
    legal = 1'b0;
    case (op)
      4'h0, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'hE: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Stage EXEC: decode the captured instruction onto the ALU operand bus
  always_comb begin
    opc_d = 8'h00;
    a_d   = '0;
    b_d   = '0;
    if (in_exec && legal) begin
      a_d = regs[rdest];
      case (op)
        4'h0: begin
          opc_d = {4'h0, ext};
          b_d   = regs[src];
        end
        4'h8: begin
          opc_d = {4'h8, ext};
          b_d   = (ext[3:1] == 3'b000) ? zext4(src) : regs[src];
        end
        4'h5, 4'h7, 4'h9, 4'hB: begin
          opc_d = {op, 4'h0};
          b_d   = sext8({ext, src});
        end
        4'h6, 4'hE: begin
          opc_d = {op, 4'h0};
          b_d   = zext8({ext, src});
        end
        4'h2: begin
          opc_d = 8'h20;
          b_d   = '0;
        end
        default: begin
          opc_d = 8'h00;
          b_d   = '0;
        end
      endcase
    end
  end

  assign alu_opcode = opc_d;
  assign alu_a      = a_d;
  assign alu_b      = b_d;
  assign err        = in_exec & ~legal;

  // WAIT, CMP-style and test-style opcodes only update flags, never R[rdest]
  always_comb begin
    wr_en  = 1'b0;
    psr_en = 1'b0;
    if (in_exec && legal) begin
      psr_en = (opc_d != 8'h00);
      wr_en  = !(opc_d inside {8'h00, 8'h0B, 8'hB0, 8'h0D});
    end
  end

  // Stage WB: results land on the EXEC->WB edge, done is visible during WB
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      instr_p0 <= '0;
      psr      <= '0;
      done_p1  <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= EXEC;
            instr_p0 <= instr;
          end
        end
        EXEC:    state <= WB;
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
      done_p1 <= in_exec & legal;
      if (wr_en)  regs[rdest] <= alu_c;
      if (psr_en) psr <= alu_flags;
    end
  end

  assign done = done_p1;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a small behavioural ALU attached.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [7:0]  alu_opcode;
  logic [15:0] alu_c;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic        done;
  logic        err;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]  ex_op;
  logic [15:0] ex_a, ex_b;
  logic        ex_err, ex_ready, ex_done;
  logic        wb_done, wb_err;
  logic        id_ready, id_done;
  logic [15:0] rv;

  alu_seq_ctrl #(.DATA_W(16), .NREG(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .alu_c(alu_c), .alu_flags(alu_flags),
    .psr(psr), .done(done), .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // ALU stand-in: subtract for CMP/SUBI, invert for NOT, add otherwise; flags {C,L,F,Z,N}
  always_comb begin
    case (alu_opcode)
      8'h0B, 8'h90: alu_c = alu_a - alu_b;
      8'h20:        alu_c = ~alu_a;
      default:      alu_c = alu_a + alu_b;
    endcase
    alu_flags = {3'b000, (alu_c == 16'h0000), alu_c[15]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [15:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  // Offers ins, then holds a competing instruction while busy (must be ignored)
  task automatic run(input logic [15:0] ins);
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    ex_op = alu_opcode; ex_a = alu_a; ex_b = alu_b;
    ex_err = err; ex_ready = instr_ready; ex_done = done;
    instr = 16'h5F01;
    @(negedge clk);
    wb_done = done; wb_err = err;
    @(negedge clk);
    instr_valid = 1'b0;
    id_ready = instr_ready; id_done = done;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0000; dbg_addr = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", instr_ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_psr", psr, 0);
    check("rst_opc", alu_opcode, 0);
    rd(4'd1, rv); check("rst_r1", rv, 16'h0000);

    run(16'h5105);
    check("addi_op", ex_op, 8'h50);
    check("addi_a", ex_a, 16'h0000);
    check("addi_b", ex_b, 16'h0005);
    check("addi_busy", ex_ready, 0);
    check("addi_exdone", ex_done, 0);
    check("addi_done", wb_done, 1);
    check("addi_done_once", id_done, 0);
    check("addi_ready", id_ready, 1);
    rd(4'd1, rv); check("addi_r1", rv, 16'h0005);

    run(16'h0251);
    check("add_op", ex_op, 8'h05);
    check("add_b", ex_b, 16'h0005);
    rd(4'd2, rv); check("add_r2", rv, 16'h0005);
    check("add_psrz", psr[1], 0);

    run(16'h01B2);
    check("cmp_op", ex_op, 8'h0B);
    check("cmp_psr", psr, 5'b00010);
    rd(4'd1, rv); check("cmp_r1", rv, 16'h0005);
    rd(4'd2, rv); check("cmp_r2", rv, 16'h0005);

    run(16'h3123);
    check("ill_err", ex_err, 1);
    check("ill_err_once", wb_err, 0);
    check("ill_done", wb_done, 0);
    check("ill_ready", id_ready, 1);
    check("ill_psr", psr, 5'b00010);
    rd(4'd1, rv); check("ill_r1", rv, 16'h0005);
    rd(4'd2, rv); check("ill_r2", rv, 16'h0005);

    run(16'h91FF);
    check("subi_op", ex_op, 8'h90);
    check("subi_b", ex_b, 16'hFFFF);
    rd(4'd1, rv); check("subi_r1", rv, 16'h0006);
    check("subi_psr", psr, 5'b00000);

    run(16'h2300);
    check("not_op", ex_op, 8'h20);
    check("not_b", ex_b, 16'h0000);
    rd(4'd3, rv); check("not_r3", rv, 16'hFFFF);
    check("not_psr", psr, 5'b00001);

    run(16'h0000);
    check("wait_op", ex_op, 8'h00);
    check("wait_done", wb_done, 1);
    check("wait_psr", psr, 5'b00001);
    rd(4'd0, rv); check("wait_r0", rv, 16'h0000);

    run(16'h8407);
    check("movi_op", ex_op, 8'h80);
    check("movi_b", ex_b, 16'h0007);
    rd(4'd4, rv); check("movi_r4", rv, 16'h0007);

    run(16'h8421);
    check("op8reg_op", ex_op, 8'h82);
    check("op8reg_b", ex_b, 16'h0006);
    rd(4'd4, rv); check("op8reg_r4", rv, 16'h000D);

    run(16'h65FF);
    check("zext_op", ex_op, 8'h60);
    check("zext_b", ex_b, 16'h00FF);
    rd(4'd5, rv); check("zext_r5", rv, 16'h00FF);

    run(16'h5603);
    run(16'h0616);
    check("same_a", ex_a, 16'h0003);
    check("same_b", ex_b, 16'h0003);
    rd(4'd6, rv); check("same_r6", rv, 16'h0006);
    rd(4'd15, rv); check("busy_ignored_r15", rv, 16'h0000);

    @(negedge clk);
    instr = 16'h5105; instr_valid = 1'b1;
    @(negedge clk);
    check("abort_op", alu_opcode, 8'h50);
    rst_n = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ready", instr_ready, 1);
    check("abort_done", done, 0);
    check("abort_psr", psr, 0);
    rd(4'd1, rv); check("abort_r1", rv, 16'h0000);
    @(negedge clk);
    check("abort_idle_opc", alu_opcode, 8'h00);
    check("abort_idle_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
